// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the multi-channel interrupt controller:
// channel state encoding, status bit offsets and the timeout timer width helper.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2
    } ch_state_e;

    localparam int ST_PEND = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_TMO  = 2;

    function automatic int timer_w(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/irq_channel.sv
// One interrupt channel: control register, IDLE/ARMED/PENDING FSM,
// saturating pending timer and sticky overrun/timeout flags.
module irq_channel
    import irq_ctrl_pkg::*;
#(
    parameter int CONTROL_WIDTH = 32,
    parameter int ENABLE_BIT    = 0,
    parameter int REARM_BIT     = 2,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CONTROL_WIDTH-1:0] wdata,
    input  logic                     evt,
    input  logic                     ack,
    output logic [CONTROL_WIDTH-1:0] ctrl,
    output logic                     pending,
    output logic                     overrun,
    output logic                     timeout
);

    localparam int            TW    = timer_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

    ch_state_e                state_q, state_d;
    logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     ovr_q, ovr_d;
    logic                     tmo_q, tmo_d;

    // Next-state: a write outranks an ack, an ack outranks a plain event.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        timer_d = timer_q;
        if (wr_en) begin
            ctrl_d = wdata;
            case (state_q)
                ST_IDLE:  state_d = wdata[ENABLE_BIT] ? ST_ARMED : ST_IDLE;
                ST_ARMED: begin
                    if (!wdata[ENABLE_BIT]) state_d = ST_IDLE;
                    else if (evt)           state_d = ST_PENDING;
                    else                    state_d = ST_ARMED;
                end
                ST_PENDING: begin
                    if (!wdata[ENABLE_BIT]) state_d = ST_IDLE;
                    else if (evt)           ovr_d   = 1'b1;
                    else                    ovr_d   = ovr_q;
                end
                default:  state_d = ST_IDLE;
            endcase
        end else if (ack && (state_q == ST_PENDING)) begin
            tmo_d = 1'b0;
            if (ctrl_q[REARM_BIT]) begin
                state_d = ST_ARMED;
                ovr_d   = evt;
            end else begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
                ovr_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_ARMED:   state_d = evt ? ST_PENDING : ST_ARMED;
                ST_PENDING: ovr_d   = ovr_q | evt;
                default:    state_d = ST_IDLE;
            endcase
        end

        // Timer restarts from zero on every entry into PENDING.
        if ((state_q == ST_PENDING) && (state_d == ST_PENDING)) begin
            timer_d = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end
        if ((state_d == ST_PENDING) && (timer_d == T_MAX)) tmo_d = 1'b1;
        else                                               tmo_d = tmo_d;
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            timer_q <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            timer_q <= timer_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign pending = (state_q == ST_PENDING);
    assign overrun = ovr_q;
    assign timeout = tmo_q;

endmodule

// File: rtl/irq_ctrl_multi.sv
// Multi-channel counter enable / interrupt controller: write decode, ctrl read mux,
// per-channel status and a registered lowest-index-wins interrupt encoder.
module irq_ctrl_multi
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CONTROL_WIDTH = 32,
    parameter int ENABLE_BIT    = 0,
    parameter int MASK_BIT      = 1,
    parameter int REARM_BIT     = 2,
    parameter int TIMEOUT_CYC   = 1024,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     write_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [CONTROL_WIDTH-1:0] ctrl_write_data,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [NUM_CH-1:0]        evt_in,
    input  logic [NUM_CH-1:0]        ack_in,
    output logic [NUM_CH-1:0]        enable,
    output logic                     irq,
    output logic [CH_W-1:0]          irq_id,
    output logic [CONTROL_WIDTH-1:0] ctrl_read_data,
    output logic [3*NUM_CH-1:0]      status
);

    logic [CONTROL_WIDTH-1:0] ctrl_s [NUM_CH];
    logic [NUM_CH-1:0]        pend_s, ovr_s, tmo_s, active_s;
    logic                     irq_q, irq_d;
    logic [CH_W-1:0]          irq_id_q, irq_id_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        irq_channel #(
            .CONTROL_WIDTH (CONTROL_WIDTH),
            .ENABLE_BIT    (ENABLE_BIT),
            .REARM_BIT     (REARM_BIT),
            .TIMEOUT_CYC   (TIMEOUT_CYC)
        ) u_ch (
            .clk     (PCLK),
            .rst     (PRESET),
            .wr_en   (write_en && (wr_ch == CH_W'(g))),
            .wdata   (ctrl_write_data),
            .evt     (evt_in[g]),
            .ack     (ack_in[g]),
            .ctrl    (ctrl_s[g]),
            .pending (pend_s[g]),
            .overrun (ovr_s[g]),
            .timeout (tmo_s[g])
        );

        assign enable[g]                = ctrl_s[g][ENABLE_BIT];
        assign active_s[g]              = pend_s[g] & ~ctrl_s[g][MASK_BIT];
        assign status[3*g + ST_PEND]    = pend_s[g];
        assign status[3*g + ST_OVR]     = ovr_s[g];
        assign status[3*g + ST_TMO]     = tmo_s[g];
    end

    assign ctrl_read_data = (int'(rd_ch) < NUM_CH) ? ctrl_s[rd_ch] : '0;

    // Priority encode: scan downwards so the lowest active index is kept.
    always_comb begin
        irq_d    = |active_s;
        irq_id_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            irq_id_d = active_s[i] ? CH_W'(i) : irq_id_d;
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Directed scoreboard bench for irq_ctrl_multi (4 channels, 8-cycle timeout).
module tb_irq_ctrl_multi;

    localparam int NUM_CH = 4;
    localparam int CW     = 32;
    localparam int CHW    = 2;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic            write_en;
    logic [CHW-1:0]  wr_ch;
    logic [CW-1:0]   ctrl_write_data;
    logic [CHW-1:0]  rd_ch;
    logic [NUM_CH-1:0] evt_in;
    logic [NUM_CH-1:0] ack_in;
    logic [NUM_CH-1:0] enable;
    logic            irq;
    logic [CHW-1:0]  irq_id;
    logic [CW-1:0]   ctrl_read_data;
    logic [3*NUM_CH-1:0] status;

    irq_ctrl_multi #(
        .NUM_CH        (NUM_CH),
        .CONTROL_WIDTH (CW),
        .ENABLE_BIT    (0),
        .MASK_BIT      (1),
        .REARM_BIT     (2),
        .TIMEOUT_CYC   (8)
    ) dut (
        .PCLK            (PCLK),
        .PRESET          (PRESET),
        .write_en        (write_en),
        .wr_ch           (wr_ch),
        .ctrl_write_data (ctrl_write_data),
        .rd_ch           (rd_ch),
        .evt_in          (evt_in),
        .ack_in          (ack_in),
        .enable          (enable),
        .irq             (irq),
        .irq_id          (irq_id),
        .ctrl_read_data  (ctrl_read_data),
        .status          (status)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: observed %0h with no expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cycle();
        @(posedge PCLK);
        #1;
        write_en = 1'b0;
        evt_in   = '0;
        ack_in   = '0;
    endtask

    task automatic wr(input int ch, input logic [31:0] d);
        write_en        = 1'b1;
        wr_ch           = CHW'(ch);
        ctrl_write_data = d;
    endtask

    task automatic rd_chk(input int ch);
        rd_ch = CHW'(ch);
        #1;
        chk(ctrl_read_data);
    endtask

    function automatic logic [31:0] st(input int ch);
        return 32'(status[3*ch +: 3]);
    endfunction

    initial begin
        PRESET = 1'b1;
        write_en = 1'b0;
        wr_ch = '0;
        ctrl_write_data = '0;
        rd_ch = '0;
        evt_in = '0;
        ack_in = '0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;

        // Reset state
        push("rst_enable", 32'h0); chk(32'(enable));
        push("rst_irq", 32'h0);    chk(32'(irq));
        push("rst_status", 32'h0); chk(32'(status));
        push("rst_ctrl0", 32'h0);  rd_chk(0);

        // Basic: ch2 enable, event, irq, ack without rearm
        wr(2, 32'h1); cycle();
        push("b_enable", 32'h4); chk(32'(enable));
        push("b_ctrl2", 32'h1);  rd_chk(2);
        evt_in = 4'b0100; cycle();
        push("b_pend2", 32'h1);  chk(32'(status[6]));
        push("b_irq_lat1", 32'h0); chk(32'(irq));
        cycle();
        push("b_irq", 32'h1);    chk(32'(irq));
        push("b_irq_id", 32'h2); chk(32'(irq_id));
        ack_in = 4'b0100; cycle();
        push("b_st2_ack", 32'h0);  chk(st(2));
        push("b_ctrl2_ack", 32'h0); rd_chk(2);
        push("b_en_ack", 32'h0);   chk(32'(enable));
        cycle();
        push("b_irq_off", 32'h0);  chk(32'(irq));

        // Priority and mask
        wr(1, 32'h1); cycle();
        wr(3, 32'h1); cycle();
        evt_in = 4'b1010; cycle();
        cycle();
        push("p_irq", 32'h1);    chk(32'(irq));
        push("p_id1", 32'h1);    chk(32'(irq_id));
        wr(1, 32'h3); cycle();
        cycle();
        push("p_id3", 32'h3);    chk(32'(irq_id));
        push("p_pend1_mask", 32'h1); chk(32'(status[3]));
        ack_in = 4'b1000; cycle();
        cycle();
        push("p_irq_off", 32'h0); chk(32'(irq));
        push("p_id_zero", 32'h0); chk(32'(irq_id));
        push("p_pend1", 32'h1);   chk(32'(status[3]));
        wr(1, 32'h0); cycle();
        push("p_st1_off", 32'h0); chk(32'(status[3]));

        // Event in IDLE is ignored
        evt_in = 4'b1000; cycle();
        push("idle_evt", 32'h0); chk(st(3));

        // Rearm and overrun on ch0
        wr(0, 32'h5); cycle();
        evt_in = 4'b0001; cycle();
        push("r_pend", 32'h1);   chk(st(0));
        evt_in = 4'b0001; cycle();
        push("r_ovr", 32'h3);    chk(st(0));
        ack_in = 4'b0001; cycle();
        push("r_st_ack", 32'h0); chk(st(0));
        push("r_en0", 32'h1);    chk(32'(enable[0]));
        push("r_ctrl0", 32'h5);  rd_chk(0);

        // Timeout: ch0 re-armed, 8 cycles in PENDING
        evt_in = 4'b0001; cycle();
        repeat (7) cycle();
        push("t_before", 32'h1); chk(st(0));
        cycle();
        push("t_at8", 32'h5);    chk(st(0));
        repeat (3) cycle();
        push("t_sticky", 32'h5); chk(st(0));
        ack_in = 4'b0001; cycle();
        push("t_ack", 32'h0);    chk(st(0));

        // Collision: write disable beats ack on a rearming channel
        wr(1, 32'h5); cycle();
        evt_in = 4'b0010; cycle();
        wr(1, 32'h0); ack_in = 4'b0010; cycle();
        push("c_pend1", 32'h0);  chk(32'(status[3]));
        push("c_en1", 32'h0);    chk(32'(enable[1]));
        // Collision: write enable plus event on an ARMED channel
        wr(0, 32'h1); evt_in = 4'b0001; cycle();
        push("c_pend0", 32'h1);  chk(32'(status[0]));
        push("c_ctrl0", 32'h1);  rd_chk(0);
        ack_in = 4'b0001; cycle();
        push("c_ack0", 32'h0);   rd_chk(0);

        // Reset mid-PENDING with irq asserted
        wr(2, 32'h1); cycle();
        evt_in = 4'b0100; cycle();
        cycle();
        push("m_irq_pre", 32'h1); chk(32'(irq));
        PRESET = 1'b1;
        #2;
        push("m_enable", 32'h0); chk(32'(enable));
        push("m_irq", 32'h0);    chk(32'(irq));
        push("m_status", 32'h0); chk(32'(status));
        push("m_ctrl2", 32'h0);  rd_chk(2);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        cycle();
        push("m_after", 32'h0);  chk(32'(status));

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
        end else begin
            checks = checks;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
